harvard_ctrl_seq: RTL and testbench
===================================

# harvard_ctrl_seq

Multi-cycle control sequencer for the 16-bit Harvard core. It fetches 32-bit instruction words from instruction memory and decodes the 6-bit opcode and register/address/immediate fields. It then drives the register-file, ALU and data-memory control signals through fetch, decode, execute, memory and writeback phases. It sits between the instruction memory, the data memory and the datapath (register file plus ALU/multiplier/barrel shifter), and owns the program counter.

## Interface
- PC_W, 8, program-counter and instruction-address width
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- run  in  1  permit new fetches; sampled only in FETCH
- imem_req  out  1  instruction read request; held until imem_valid
- imem_addr  out  PC_W  current PC
- imem_rdata  in  32  instruction word
- imem_valid  in  1  imem_rdata valid; may be asserted in the same cycle as imem_req
- dmem_req  out  1  data-memory request; held until dmem_ack
- dmem_we  out  1  1 = store
- dmem_addr  out  8  load address = instr[7:0]; store address = instr[25:18]
- dmem_ack  in  1  access complete
- rf_raddr_a  out  5  Rsrc1 = instr[4:0]
- rf_raddr_b  out  5  Rsrc2 = instr[9:5]
- rf_waddr  out  5  writeback register
- rf_we  out  1  register write strobe, one cycle
- wb_sel  out  2  0 = immediate, 1 = rf port A, 2 = dmem data, 3 = ALU result
- wb_hi  out  1  select the ALU high half (multiply only)
- imm  out  16  instr[15:0]
- alu_op  out  4  opcode[3:0] for opcodes 4..16, where 16 maps to 0
- alu_shr  out  1  opcode == 16
- alu_start  out  1  one-cycle pulse on EXEC entry
- alu_done  in  1  ALU result ready; may be asserted in the same cycle as alu_start
- busy  out  1  state is not IDLE and not TRAP
- trap  out  1  illegal opcode seen; sticky until rst

## Operation
- Opcodes and their actions:
  - 0 LDI: Rdst2 ← imm
  - 1 MOV: Rdst2 ← Rsrc1. Rsrc1 is taken from instr[4:0]; only the low 5 bits of every register field are meaningful.
  - 2 LD: Rdst2 ← mem[instr[7:0]]
  - 3 ST: mem[instr[25:18]] ← Rsrc1
  - 4..16 ALU (add, sub, neg, mul, and, or, xor, nand, nor, xnor, not, shl, shr): Rdst1 ← result
  - 7 MUL additionally writes Rdst2 ← high 16 bits of the product.
  - 17..63: illegal.
- Field positions: Rdst2 = [25:21], Rdst1 = [20:16].
- States and transitions:
  - IDLE: go to FETCH when run = 1.
  - FETCH: if run = 0, go to IDLE. Otherwise assert imem_req. On imem_valid, latch the instruction register (IR) and go to DECODE.
  - DECODE: PC ← PC + 1, wrapping modulo 2^PC_W.
    - Illegal opcode: go to TRAP.
    - Opcode 0 or 1: go to WB.
    - Opcode 2 or 3: go to MEM.
    - Otherwise: go to EXEC.
  - EXEC: alu_start on entry; wait for alu_done, then go to WB.
  - MEM: dmem_req held until dmem_ack. On ack, a load goes to WB and a store goes to FETCH.
  - WB: rf_we = 1. If MUL, go to WB_HI; otherwise go to FETCH.
  - WB_HI: rf_we = 1, wb_hi = 1, rf_waddr = Rdst2; then go to FETCH.
  - TRAP: hold until rst. No requests are issued and the PC is frozen.
- In WB, rf_waddr is Rdst1 for ALU opcodes and Rdst2 for opcodes 0..2.
- All outputs are registered or decoded from the state and IR only. No output depends combinationally on imem_rdata.

## Timing
- Reset values:
  - state = IDLE, PC = 0, IR = 0.
  - All strobes and requests = 0: imem_req, dmem_req, dmem_we, rf_we, alu_start, wb_hi, busy, trap.
  - All address and data outputs = 0.
- Minimum latency from FETCH entry to the next FETCH, with zero-wait memories and ALU:
  - LDI / MOV: 3 cycles
  - ST: 3 cycles
  - LD: 4 cycles
  - ALU: 4 cycles
  - MUL: 5 cycles
- Each wait on imem_valid, dmem_ack or alu_done extends the cycle count one-for-one.
- rf_we is high for exactly one cycle per write.
- imem_req and dmem_req stay stable until accepted. Address outputs are stable while the corresponding request is high.
- Stalls: run = 0 during EXEC, MEM or WB does not stall; the instruction completes and the sequencer stops at the next FETCH.
- Simultaneous events:
  - run falling in the same cycle as imem_valid in FETCH: run wins. The sequencer goes to IDLE, the fetched word is discarded and the PC is unchanged.
- Reset mid-operation: on the next edge, all state returns to reset values and any outstanding request is dropped. Memories must tolerate an abandoned request.
- PC wrap: 2^PC_W − 1 increments to 0 with no flag.

## Structure
- Package harvard_pkg:
  - opcode enum (OP_LDI..OP_SHR)
  - state enum
  - field bit-position constants
  - wb_sel encodings
- Sub-module harvard_ir_decode: combinational. Takes IR and produces the field extracts, class flags (imm, mov, ld, st, alu, mul), illegal flag and alu_op. Instantiated once.
- Top level: FSM, PC, IR.

## Test plan
- LDI: IR = 0x0020_1234 → WB cycle with rf_waddr = 1, wb_sel = 0, imm = 0x1234, rf_we for 1 cycle; 3 cycles total.
- ADD, with alu_done delayed 2 cycles: Rdst1 = 3, Rsrc2 = 2, Rsrc1 = 1 → alu_start once, alu_op = 4, rf_waddr = 3 on WB; 6 cycles total.
- MUL: Rdst2 = 5, Rdst1 = 4 → WB writes register 4 with wb_hi = 0, then WB_HI writes register 5 with wb_hi = 1.
- LD at address 0x3C with dmem_ack after 3 cycles → dmem_req held 4 cycles with dmem_we = 0, then wb_sel = 2. ST at address 0xA5 → dmem_we = 1, no rf_we.
- Opcode 0x3F → trap = 1 and busy = 0; no further imem_req until rst; PC = 1.
- Control boundaries:
  - PC = 0xFF → next imem_addr = 0x00.
  - rst asserted during MEM → all outputs at reset values next cycle.
  - run dropped while imem_valid = 1 → IDLE, PC unchanged.

Source files
------------

// File: rtl/harvard_pkg.sv
// Shared types and constants for the Harvard core control sequencer.
// Opcodes, FSM state codes, IR field positions and writeback selects.
package harvard_pkg;

    typedef enum logic [5:0] {
        OP_LDI  = 6'd0,
        OP_MOV  = 6'd1,
        OP_LD   = 6'd2,
        OP_ST   = 6'd3,
        OP_ADD  = 6'd4,
        OP_SUB  = 6'd5,
        OP_NEG  = 6'd6,
        OP_MUL  = 6'd7,
        OP_AND  = 6'd8,
        OP_OR   = 6'd9,
        OP_XOR  = 6'd10,
        OP_NAND = 6'd11,
        OP_NOR  = 6'd12,
        OP_XNOR = 6'd13,
        OP_NOT  = 6'd14,
        OP_SHL  = 6'd15,
        OP_SHR  = 6'd16
    } opcode_e;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_WB_HI  = 3'd6;
    localparam logic [2:0] ST_TRAP   = 3'd7;

    localparam int OPC_LSB = 26;
    localparam int RD2_LSB = 21;
    localparam int RD1_LSB = 16;
    localparam int STA_LSB = 18;
    localparam int RS2_LSB = 5;
    localparam int RS1_LSB = 0;
    localparam int LDA_LSB = 0;
    localparam int IMM_LSB = 0;

    localparam logic [1:0] WB_IMM  = 2'd0;
    localparam logic [1:0] WB_RFA  = 2'd1;
    localparam logic [1:0] WB_DMEM = 2'd2;
    localparam logic [1:0] WB_ALU  = 2'd3;

endpackage

// File: rtl/harvard_ir_decode.sv
// Combinational instruction-register decoder.
// Extracts fields, class flags, ALU op and writeback select.
module harvard_ir_decode
    import harvard_pkg::*;
(
    input  logic [31:0] ir,
    output logic [4:0]  rsrc1,
    output logic [4:0]  rsrc2,
    output logic [4:0]  rdst1,
    output logic [4:0]  rdst2,
    output logic [7:0]  dmem_addr,
    output logic [15:0] imm,
    output logic [1:0]  wb_sel,
    output logic        is_imm,
    output logic        is_mov,
    output logic        is_ld,
    output logic        is_st,
    output logic        is_alu,
    output logic        is_mul,
    output logic        illegal,
    output logic [3:0]  alu_op,
    output logic        alu_shr
);

    logic [5:0] opcode;

    assign opcode    = ir[OPC_LSB +: 6];
    assign rsrc1     = ir[RS1_LSB +: 5];
    assign rsrc2     = ir[RS2_LSB +: 5];
    assign rdst1     = ir[RD1_LSB +: 5];
    assign rdst2     = ir[RD2_LSB +: 5];
    assign imm       = ir[IMM_LSB +: 16];

    assign is_imm    = (opcode == OP_LDI);
    assign is_mov    = (opcode == OP_MOV);
    assign is_ld     = (opcode == OP_LD);
    assign is_st     = (opcode == OP_ST);
    assign is_mul    = (opcode == OP_MUL);
    assign is_alu    = (opcode >= OP_ADD) && (opcode <= OP_SHR);
    assign illegal   = (opcode > OP_SHR);

    // opcode 16 (shr) folds onto op 0 with a separate direction flag
    assign alu_op    = is_alu ? opcode[3:0] : 4'd0;
    assign alu_shr   = (opcode == OP_SHR);

    assign dmem_addr = is_st ? ir[STA_LSB +: 8] : ir[LDA_LSB +: 8];

    // writeback source by instruction class
    always_comb begin
        wb_sel = WB_IMM;
        unique case (1'b1)
            is_imm:  wb_sel = WB_IMM;
            is_mov:  wb_sel = WB_RFA;
            is_ld:   wb_sel = WB_DMEM;
            is_alu:  wb_sel = WB_ALU;
            default: wb_sel = WB_IMM;
        endcase
    end

endmodule

// File: rtl/harvard_ctrl_seq.sv
// Multi-cycle control sequencer: FSM, program counter and IR.
// All outputs decode from state and IR, never from imem_rdata.
module harvard_ctrl_seq
    import harvard_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_valid,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [7:0]      dmem_addr,
    input  logic            dmem_ack,
    output logic [4:0]      rf_raddr_a,
    output logic [4:0]      rf_raddr_b,
    output logic [4:0]      rf_waddr,
    output logic            rf_we,
    output logic [1:0]      wb_sel,
    output logic            wb_hi,
    output logic [15:0]     imm,
    output logic [3:0]      alu_op,
    output logic            alu_shr,
    output logic            alu_start,
    input  logic            alu_done,
    output logic            busy,
    output logic            trap
);

    logic [2:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic            alu_start_q, alu_start_d;

    logic [4:0] rdst1, rdst2;
    logic       is_imm, is_mov, is_ld, is_st;
    logic       is_alu, is_mul, illegal;

    harvard_ir_decode u_dec (
        .ir        (ir_q),
        .rsrc1     (rf_raddr_a),
        .rsrc2     (rf_raddr_b),
        .rdst1     (rdst1),
        .rdst2     (rdst2),
        .dmem_addr (dmem_addr),
        .imm       (imm),
        .wb_sel    (wb_sel),
        .is_imm    (is_imm),
        .is_mov    (is_mov),
        .is_ld     (is_ld),
        .is_st     (is_st),
        .is_alu    (is_alu),
        .is_mul    (is_mul),
        .illegal   (illegal),
        .alu_op    (alu_op),
        .alu_shr   (alu_shr)
    );

    // next-state, PC and IR update
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                // run wins over a word arriving in the same cycle
                if (!run) begin
                    state_d = ST_IDLE;
                end else if (imem_valid) begin
                    ir_d    = imem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                pc_d = pc_q + 1'b1;
                if (illegal)
                    state_d = ST_TRAP;
                else if (is_imm || is_mov)
                    state_d = ST_WB;
                else if (is_ld || is_st)
                    state_d = ST_MEM;
                else
                    state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (alu_done) state_d = ST_WB;
            end
            ST_MEM: begin
                if (dmem_ack) state_d = is_st ? ST_FETCH : ST_WB;
            end
            ST_WB: begin
                state_d = is_mul ? ST_WB_HI : ST_FETCH;
            end
            ST_WB_HI: begin
                state_d = ST_FETCH;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        alu_start_d = (state_d == ST_EXEC) && (state_q != ST_EXEC);
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            ir_q        <= '0;
            alu_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            alu_start_q <= alu_start_d;
        end
    end

    assign imem_req  = (state_q == ST_FETCH);
    assign imem_addr = pc_q;
    assign dmem_req  = (state_q == ST_MEM);
    assign dmem_we   = dmem_req && is_st;
    assign rf_we     = (state_q == ST_WB) || (state_q == ST_WB_HI);
    assign wb_hi     = (state_q == ST_WB_HI);
    assign rf_waddr  = (wb_hi || !is_alu) ? rdst2 : rdst1;
    assign alu_start = alu_start_q;
    assign trap      = (state_q == ST_TRAP);
    assign busy      = (state_q != ST_IDLE) && !trap;

endmodule

// File: tb/tb_harvard_ctrl_seq.sv
// Scoreboard bench for harvard_ctrl_seq.
// Expected writebacks are queued at fetch and popped on rf_we.
module tb_harvard_ctrl_seq;

    logic        clk = 1'b0;
    logic        rst, run;
    logic        imem_req, imem_valid;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [7:0]  dmem_addr;
    logic [4:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
    logic        rf_we, wb_hi, alu_shr, alu_start, alu_done;
    logic [1:0]  wb_sel;
    logic [15:0] imm;
    logic [3:0]  alu_op;
    logic        busy, trap;

    harvard_ctrl_seq #(.PC_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_ack   (dmem_ack),
        .rf_raddr_a (rf_raddr_a),
        .rf_raddr_b (rf_raddr_b),
        .rf_waddr   (rf_waddr),
        .rf_we      (rf_we),
        .wb_sel     (wb_sel),
        .wb_hi      (wb_hi),
        .imm        (imm),
        .alu_op     (alu_op),
        .alu_shr    (alu_shr),
        .alu_start  (alu_start),
        .alu_done   (alu_done),
        .busy       (busy),
        .trap       (trap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  waddr;
        logic [1:0]  sel;
        logic        hi;
        logic [15:0] imm;
    } wb_t;

    wb_t exp_q[$];
    int  vec = 0;
    int  miscmp = 0;
    logic [7:0] exp_pc = 8'd0;

    int         obs_cyc, obs_start, obs_dreq, obs_we;
    logic       obs_dwe, obs_shr;
    logic [7:0] obs_daddr;
    logic [3:0] obs_alu_op;

    function automatic wb_t mk(input logic [4:0] a, input logic [1:0] s,
                               input logic h, input logic [15:0] i);
        wb_t w;
        w.waddr = a;
        w.sel   = s;
        w.hi    = h;
        w.imm   = i;
        return w;
    endfunction

    // writeback scoreboard
    always @(negedge clk) begin
        wb_t e;
        if (!rst && rf_we) begin
            vec++;
            if (exp_q.size() == 0) begin
                miscmp++;
                $display("FAIL wb_unexpected waddr=%0d none expected", rf_waddr);
            end else begin
                e = exp_q.pop_front();
                if ({rf_waddr, wb_sel, wb_hi} !== {e.waddr, e.sel, e.hi}) begin
                    miscmp++;
                    $display("FAIL wb_fields got a=%0d s=%0d h=%0d want a=%0d s=%0d h=%0d",
                             rf_waddr, wb_sel, wb_hi, e.waddr, e.sel, e.hi);
                end
                if (e.sel == 2'd0 && imm !== e.imm) begin
                    miscmp++;
                    $display("FAIL wb_imm got %h want %h", imm, e.imm);
                end
            end
        end
    end

    // drive one instruction from FETCH to the next FETCH (or TRAP)
    task automatic run_instr(input logic [31:0] ins, input int iw,
                             input int aw, input int dw);
        int iwc, awc, dwc;
        bit served, in_exec, done;
        iwc = 0; awc = 0; dwc = 0;
        served = 0; in_exec = 0; done = 0;
        obs_cyc = 0; obs_start = 0; obs_dreq = 0; obs_we = 0;
        obs_dwe = 0; obs_shr = 0; obs_daddr = '0; obs_alu_op = '0;
        for (int k = 0; k < 64; k++) begin
            imem_valid = 0; alu_done = 0; dmem_ack = 0;
            imem_rdata = $urandom;
            if (trap || (imem_req && served)) begin
                done = 1;
                break;
            end
            obs_cyc++;
            if (rf_we) obs_we++;
            if (imem_req) begin
                if (iwc == iw) begin
                    imem_valid = 1;
                    imem_rdata = ins;
                    served = 1;
                end else iwc++;
            end
            if (alu_start) begin
                in_exec = 1; awc = 0; obs_start++;
                obs_alu_op = alu_op; obs_shr = alu_shr;
            end
            if (in_exec) begin
                if (awc == aw) begin
                    alu_done = 1; in_exec = 0;
                end else awc++;
            end
            if (dmem_req) begin
                obs_dreq++;
                obs_daddr = dmem_addr;
                if (dmem_we) obs_dwe = 1;
                if (dwc == dw) dmem_ack = 1;
                else dwc++;
            end
            @(negedge clk);
        end
        if (!done) begin
            vec++; miscmp++;
            $display("FAIL instr_timeout ins=%h got no fetch want fetch", ins);
        end
        if (served) exp_pc++;
    endtask

    task automatic wait_fetch();
        bit ok;
        ok = 0;
        for (int k = 0; k < 10; k++) begin
            if (imem_req) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            vec++; miscmp++;
            $display("FAIL fetch_timeout got req=0 want 1");
        end
    endtask

    task automatic test_reset();
        rst = 1; run = 0; imem_valid = 0; imem_rdata = '0;
        dmem_ack = 0; alu_done = 0;
        repeat (3) @(negedge clk);
        vec++;
        if ({imem_req, dmem_req, dmem_we, rf_we, alu_start,
             wb_hi, busy, trap, alu_shr} !== 9'd0) begin
            miscmp++;
            $display("FAIL reset_strobes got %b want 0",
                     {imem_req, dmem_req, dmem_we, rf_we, alu_start,
                      wb_hi, busy, trap, alu_shr});
        end
        vec++;
        if ({imem_addr, dmem_addr, rf_raddr_a, rf_raddr_b, rf_waddr,
             wb_sel, imm, alu_op} !== 55'd0) begin
            miscmp++;
            $display("FAIL reset_data got nonzero want 0");
        end
        rst = 0; run = 1;
        @(negedge clk);
        wait_fetch();
        vec++;
        if (imem_addr !== 8'd0) begin
            miscmp++;
            $display("FAIL reset_pc got %h want 00", imem_addr);
        end
    endtask

    task automatic test_ldi();
        exp_q.push_back(mk(5'd1, 2'd0, 1'b0, 16'h1234));
        run_instr(32'h0020_1234, 0, 0, 0);
        vec++;
        if (obs_cyc !== 3) begin
            miscmp++;
            $display("FAIL ldi_cycles got %0d want 3", obs_cyc);
        end
        vec++;
        if (obs_we !== 1) begin
            miscmp++;
            $display("FAIL ldi_we got %0d want 1", obs_we);
        end
    endtask

    task automatic test_mov();
        exp_q.push_back(mk(5'd7, 2'd1, 1'b0, 16'h0));
        run_instr((32'd1 << 26) | (32'd7 << 21) | 32'd9, 1, 0, 0);
        vec++;
        if (obs_cyc !== 4) begin
            miscmp++;
            $display("FAIL mov_cycles got %0d want 4", obs_cyc);
        end
    endtask

    task automatic test_add();
        exp_q.push_back(mk(5'd3, 2'd3, 1'b0, 16'h0));
        run_instr((32'd4 << 26) | (32'd3 << 16) | (32'd2 << 5) | 32'd1,
                  0, 2, 0);
        vec++;
        if (obs_cyc !== 6) begin
            miscmp++;
            $display("FAIL add_cycles got %0d want 6", obs_cyc);
        end
        vec++;
        if (obs_start !== 1 || obs_alu_op !== 4'd4) begin
            miscmp++;
            $display("FAIL add_start got n=%0d op=%0d want n=1 op=4",
                     obs_start, obs_alu_op);
        end
    endtask

    task automatic test_mul();
        exp_q.push_back(mk(5'd4, 2'd3, 1'b0, 16'h0));
        exp_q.push_back(mk(5'd5, 2'd3, 1'b1, 16'h0));
        run_instr((32'd7 << 26) | (32'd5 << 21) | (32'd4 << 16), 0, 0, 0);
        vec++;
        if (obs_cyc !== 5 || obs_we !== 2) begin
            miscmp++;
            $display("FAIL mul_timing got cyc=%0d we=%0d want cyc=5 we=2",
                     obs_cyc, obs_we);
        end
    endtask

    task automatic test_ld_st();
        exp_q.push_back(mk(5'd6, 2'd2, 1'b0, 16'h0));
        run_instr((32'd2 << 26) | (32'd6 << 21) | 32'h3C, 0, 0, 3);
        vec++;
        if (obs_dreq !== 4 || obs_dwe !== 1'b0 || obs_daddr !== 8'h3C) begin
            miscmp++;
            $display("FAIL ld_mem got req=%0d we=%0d a=%h want 4 0 3c",
                     obs_dreq, obs_dwe, obs_daddr);
        end
        vec++;
        if (obs_cyc !== 7) begin
            miscmp++;
            $display("FAIL ld_cycles got %0d want 7", obs_cyc);
        end
        run_instr((32'd3 << 26) | (32'hA5 << 18) | 32'd2, 0, 0, 0);
        vec++;
        if (obs_dwe !== 1'b1 || obs_daddr !== 8'hA5 || obs_we !== 0) begin
            miscmp++;
            $display("FAIL st_mem got we=%0d a=%h rfwe=%0d want 1 a5 0",
                     obs_dwe, obs_daddr, obs_we);
        end
        vec++;
        if (obs_cyc !== 3) begin
            miscmp++;
            $display("FAIL st_cycles got %0d want 3", obs_cyc);
        end
    endtask

    task automatic test_back_to_back();
        for (int op = 4; op <= 16; op++) begin
            int aw, iw, want;
            logic [4:0]  r1, r2;
            logic [5:0]  opc;
            logic [3:0]  wop;
            logic [31:0] ins;
            aw  = $urandom_range(0, 3);
            iw  = $urandom_range(0, 2);
            r1  = 5'($urandom);
            r2  = 5'($urandom);
            opc = 6'(op);
            ins = {opc, r2, r1, 16'($urandom)};
            wop = (op == 16) ? 4'd0 : opc[3:0];
            want = 4 + aw + iw + ((op == 7) ? 1 : 0);
            exp_q.push_back(mk(r1, 2'd3, 1'b0, 16'h0));
            if (op == 7) exp_q.push_back(mk(r2, 2'd3, 1'b1, 16'h0));
            run_instr(ins, iw, aw, 0);
            vec++;
            if (obs_cyc !== want) begin
                miscmp++;
                $display("FAIL b2b_cycles op=%0d got %0d want %0d",
                         op, obs_cyc, want);
            end
            vec++;
            if (obs_alu_op !== wop || obs_shr !== (op == 16)) begin
                miscmp++;
                $display("FAIL b2b_aluop op=%0d got %0d/%0d want %0d/%0d",
                         op, obs_alu_op, obs_shr, wop, (op == 16));
            end
        end
    endtask

    task automatic test_run_drop();
        run = 0;
        imem_valid = 1;
        imem_rdata = 32'h0040_5555;
        @(negedge clk);
        imem_valid = 0;
        vec++;
        if (busy !== 1'b0 || imem_req !== 1'b0) begin
            miscmp++;
            $display("FAIL run_drop_idle got busy=%0d req=%0d want 0 0",
                     busy, imem_req);
        end
        run = 1;
        @(negedge clk);
        vec++;
        if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
            miscmp++;
            $display("FAIL run_drop_pc got req=%0d pc=%h want 1 %h",
                     imem_req, imem_addr, exp_pc);
        end
    endtask

    task automatic test_pc_wrap();
        int n;
        n = 255 - int'(exp_pc);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(mk(5'd2, 2'd0, 1'b0, 16'(i)));
            run_instr((32'd2 << 21) | 32'(i[15:0]), 0, 0, 0);
        end
        vec++;
        if (imem_addr !== 8'hFF) begin
            miscmp++;
            $display("FAIL pc_pre_wrap got %h want ff", imem_addr);
        end
        exp_q.push_back(mk(5'd3, 2'd0, 1'b0, 16'hBEEF));
        run_instr((32'd3 << 21) | 32'hBEEF, 0, 0, 0);
        vec++;
        if (imem_addr !== 8'h00) begin
            miscmp++;
            $display("FAIL pc_wrap got %h want 00", imem_addr);
        end
    endtask

    task automatic test_rst_mem();
        bit ok;
        ok = 0;
        imem_valid = 1;
        imem_rdata = (32'd2 << 26) | (32'd9 << 21) | 32'h77;
        @(negedge clk);
        imem_valid = 0;
        for (int k = 0; k < 5; k++) begin
            if (dmem_req) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        vec++;
        if (!ok) begin
            miscmp++;
            $display("FAIL rst_mem_reach got req=0 want 1");
        end
        rst = 1;
        @(negedge clk);
        vec++;
        if ({imem_req, dmem_req, dmem_we, rf_we, alu_start,
             wb_hi, busy, trap, alu_shr} !== 9'd0) begin
            miscmp++;
            $display("FAIL rst_mem_strobes got %b want 0",
                     {imem_req, dmem_req, dmem_we, rf_we, alu_start,
                      wb_hi, busy, trap, alu_shr});
        end
        vec++;
        if ({imem_addr, dmem_addr, rf_raddr_a, rf_raddr_b, rf_waddr,
             wb_sel, imm, alu_op} !== 55'd0) begin
            miscmp++;
            $display("FAIL rst_mem_data got nonzero want 0");
        end
        rst = 0;
        exp_pc = 8'd0;
        vec++;
        if (exp_q.size() != 0) begin
            miscmp++;
            $display("FAIL wb_missing got %0d pending want 0", exp_q.size());
        end
        @(negedge clk);
        wait_fetch();
    endtask

    task automatic test_trap();
        bit seen;
        seen = 0;
        run_instr(32'hFC00_0000, 0, 0, 0);
        vec++;
        if (trap !== 1'b1 || busy !== 1'b0 || imem_addr !== 8'd1) begin
            miscmp++;
            $display("FAIL trap_state got t=%0d b=%0d pc=%h want 1 0 01",
                     trap, busy, imem_addr);
        end
        for (int k = 0; k < 10; k++) begin
            if (imem_req || dmem_req || rf_we || imem_addr !== 8'd1) seen = 1;
            @(negedge clk);
        end
        vec++;
        if (seen || trap !== 1'b1) begin
            miscmp++;
            $display("FAIL trap_hold got activity=%0d t=%0d want 0 1",
                     seen, trap);
        end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_mov();
        test_add();
        test_mul();
        test_ld_st();
        test_back_to_back();
        test_run_drop();
        test_pc_wrap();
        test_rst_mem();
        test_trap();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

endmodule
